// File: rtl/dmem_pkg.sv
// dmem_pkg: constants and types shared by the data-memory read and store paths.
//   S      scalar word width / address width
//   LANES  words per vector
//   V      vector width (LANES*S)
//   SIZE   data-memory depth in words
package dmem_pkg;

  localparam int S     = 32;
  localparam int LANES = 6;
  localparam int V     = LANES * S;
  localparam int SIZE  = 30000;

  // Lane index / word count width; 3 bits covers counts 1..6 and indices 0..5.
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] IDX_ZERO  = 3'd0;
  localparam logic [IDX_W-1:0] IDX_ONE   = 3'd1;
  localparam logic [IDX_W-1:0] IDX_LANES = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } store_state_t;

  // True when words addr .. addr+cnt-1 all lie inside the memory.
  // The sum is formed one bit wider than the address so a base near the
  // top of the address space cannot wrap around and look legal.
  function automatic logic fits_in_mem(input logic [S-1:0] addr,
                                       input logic [IDX_W-1:0] cnt);
    logic [S:0] sum;
    sum = {1'b0, addr} + {{(S+1-IDX_W){1'b0}}, cnt};
    return (sum <= (S+1)'(SIZE));
  endfunction

endpackage

// File: rtl/dmem_lane_sel.sv
// dmem_lane_sel: picks one S-bit word out of a V-bit vector.
//   data  in  V      packed vector, lane k at data[k*S +: S]
//   idx   in  IDX_W  lane index
//   word  out S      selected lane; zero for an index beyond the last lane
module dmem_lane_sel
  import dmem_pkg::*;
(
  input  logic [V-1:0]     data,
  input  logic [IDX_W-1:0] idx,
  output logic [S-1:0]     word
);

  // Lane multiplexer; unused index codes return zero rather than stale data.
  always_comb begin
    word = {S{1'b0}};
    case (idx)
      3'd0:    word = data[0*S +: S];
      3'd1:    word = data[1*S +: S];
      3'd2:    word = data[2*S +: S];
      3'd3:    word = data[3*S +: S];
      3'd4:    word = data[4*S +: S];
      3'd5:    word = data[5*S +: S];
      default: word = {S{1'b0}};
    endcase
  end

endmodule

// File: rtl/dmem_store_seq.sv
// dmem_store_seq: accepts scalar or 6-lane vector store requests and
// serializes them into single-word writes on the RAM write port.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready is combinational
//                           from mem_gnt during the last write)
//   req_isVector            1 = vector store (LANES words), 0 = scalar
//   req_address, req_data   base word address and store data
//   mem_we/addr/wd          registered word write to the RAM
//   mem_gnt                 RAM accepts the current write
//   done                    pulse: request fully written
//   err                     pulse: request rejected (out of range)
module dmem_store_seq
  import dmem_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_isVector,
  input  logic [S-1:0] req_address,
  input  logic [V-1:0] req_data,
  output logic         mem_we,
  output logic [S-1:0] mem_addr,
  output logic [S-1:0] mem_wd,
  input  logic         mem_gnt,
  output logic         done,
  output logic         err
);

  store_state_t     state_r,    nxt_state_s;
  logic [S-1:0]     base_r,     nxt_base_s;
  logic [V-1:0]     data_r,     nxt_data_s;
  logic [IDX_W-1:0] idx_r,      nxt_idx_s;
  logic [IDX_W-1:0] cnt_r,      nxt_cnt_s;
  logic             err_pend_r, nxt_err_pend_s;

  logic             nxt_done_s;
  logic             nxt_err_s;
  logic             err_hit_s;
  logic             last_s;
  logic             accept_s;
  logic [IDX_W-1:0] req_cnt_s;
  logic             req_fits_s;
  logic             nxt_we_s;
  logic [S-1:0]     nxt_addr_s;
  logic [S-1:0]     nxt_wd_s;
  logic [S-1:0]     sel_word_s;

  // Next-word data comes from the lane selector so mem_wd can be registered.
  dmem_lane_sel u_lane_sel (
    .data (nxt_data_s),
    .idx  (nxt_idx_s),
    .word (sel_word_s)
  );

  // Handshake, range check and next-state / next-output computation.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_base_s     = base_r;
    nxt_data_s     = data_r;
    nxt_idx_s      = idx_r;
    nxt_cnt_s      = cnt_r;
    nxt_done_s     = 1'b0;
    err_hit_s      = 1'b0;

    last_s     = (idx_r == (cnt_r - IDX_ONE));
    req_ready  = (state_r == IDLE) || ((state_r == WRITE) && last_s && mem_gnt);
    accept_s   = req_valid && req_ready;
    req_cnt_s  = req_isVector ? IDX_LANES : IDX_ONE;
    req_fits_s = fits_in_mem(req_address, req_cnt_s);

    // Progress of the request currently being written.
    case (state_r)
      IDLE: begin
        nxt_state_s = IDLE;
      end
      WRITE: begin
        if (mem_gnt) begin
          if (last_s) begin
            nxt_done_s  = 1'b1;
            nxt_state_s = IDLE;
          end else begin
            nxt_idx_s = idx_r + IDX_ONE;
          end
        end else begin
          // Stalled: everything holds.
          nxt_state_s = WRITE;
        end
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase

    // A newly accepted request overrides the return to IDLE.
    if (accept_s) begin
      if (req_fits_s) begin
        nxt_state_s = WRITE;
        nxt_base_s  = req_address;
        nxt_data_s  = req_data;
        nxt_cnt_s   = req_cnt_s;
        nxt_idx_s   = IDX_ZERO;
      end else begin
        err_hit_s = 1'b1;
      end
    end else begin
      err_hit_s = 1'b0;
    end

    // done and err must never pulse together: a rejection accepted in the
    // completing cycle of the previous request reports one cycle later.
    nxt_err_s      = (err_hit_s && !nxt_done_s) || err_pend_r;
    nxt_err_pend_s = err_hit_s && nxt_done_s;

    nxt_we_s = (nxt_state_s == WRITE);
    if (nxt_we_s) begin
      nxt_addr_s = nxt_base_s + {{(S-IDX_W){1'b0}}, nxt_idx_s};
      nxt_wd_s   = sel_word_s;
    end else begin
      nxt_addr_s = {S{1'b0}};
      nxt_wd_s   = {S{1'b0}};
    end
  end

  // State, request registers and registered RAM/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      base_r     <= {S{1'b0}};
      data_r     <= {V{1'b0}};
      idx_r      <= IDX_ZERO;
      cnt_r      <= IDX_ONE;
      err_pend_r <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {S{1'b0}};
      mem_wd     <= {S{1'b0}};
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      base_r     <= nxt_base_s;
      data_r     <= nxt_data_s;
      idx_r      <= nxt_idx_s;
      cnt_r      <= nxt_cnt_s;
      err_pend_r <= nxt_err_pend_s;
      mem_we     <= nxt_we_s;
      mem_addr   <= nxt_addr_s;
      mem_wd     <= nxt_wd_s;
      done       <= nxt_done_s;
      err        <= nxt_err_s;
    end
  end

endmodule

// File: tb/tb_dmem_store_seq.sv
// tb_dmem_store_seq: scoreboard bench for dmem_store_seq. The stimulus
// process pushes cycle-stamped expected writes and done/err events; a
// monitor pops and compares them whenever the DUT commits a write or
// pulses done/err.
module tb_dmem_store_seq;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_isVector;
  logic [31:0]  req_address;
  logic [191:0] req_data;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wd;
  logic         mem_gnt;
  logic         done;
  logic         err;

  dmem_store_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_isVector (req_isVector),
    .req_address  (req_address),
    .req_data     (req_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_gnt      (mem_gnt),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wexp_t;

  typedef struct {
    int cyc;
    bit is_err;
  } eexp_t;

  wexp_t wq[$];
  eexp_t eq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  localparam logic [191:0] VEC_A = {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [191:0] VEC_B = {32'hB0B0_0006, 32'hB0B0_0005, 32'hB0B0_0004,
                                    32'hB0B0_0003, 32'hB0B0_0002, 32'hB0B0_0001};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every committed write and every done/err pulse.
  always @(negedge clk) begin
    wexp_t w;
    eexp_t e;
    if (mem_we && mem_gnt) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none (cycle %0d)",
                 mem_addr, mem_wd, cyc);
      end else begin
        w = wq.pop_front();
        chk("write_cycle", 64'(cyc), 64'(w.cyc));
        chk("write_addr", 64'(mem_addr), 64'(w.addr));
        chk("write_data", 64'(mem_wd), 64'(w.data));
      end
    end
    if (done || err) begin
      chk("done_err_exclusive", 64'(done & err), 64'd0);
      if (eq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got done=%0b err=%0b expected none (cycle %0d)",
                 done, err, cyc);
      end else begin
        e = eq.pop_front();
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        chk("event_is_err", 64'(err), 64'(e.is_err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit isv, input logic [31:0] a, input logic [191:0] d);
    req_valid    = v;
    req_isVector = isv;
    req_address  = a;
    req_data     = d;
  endtask

  task automatic exp_w(input int c, input logic [31:0] a, input logic [31:0] d);
    wq.push_back('{cyc: c, addr: a, data: d});
  endtask

  task automatic exp_e(input int c, input bit is_err);
    eq.push_back('{cyc: c, is_err: is_err});
  endtask

  // Ungated vector store accepted at the end of cycle c0.
  task automatic exp_vec(input int c0, input logic [31:0] a, input logic [191:0] d);
    for (int i = 0; i < 6; i++) begin
      exp_w(c0 + 1 + i, a + 32'(i), d[i*32 +: 32]);
    end
    exp_e(c0 + 7, 1'b0);
  endtask

  // Present one request for one cycle; c returns the cycle it was presented in.
  task automatic issue(output int c, input bit isv, input logic [31:0] a, input logic [191:0] d);
    step();
    c = cyc;
    drive(1'b1, isv, a, d);
    step();
    drive(1'b0, 1'b0, 32'h0, 192'h0);
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while ((wq.size() != 0 || eq.size() != 0) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d writes %0d events pending expected 0", wq.size(), eq.size());
      wq.delete();
      eq.delete();
    end
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c1;
    rst_n   = 1'b1;
    mem_gnt = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 192'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wd", 64'(mem_wd), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: scalar store
    issue(c, 1'b0, 32'd100, {160'h0, 32'hDEAD_BEEF});
    exp_w(c + 1, 32'd100, 32'hDEAD_BEEF);
    exp_e(c + 2, 1'b0);
    drain();

    // 2: vector store, grant always high
    issue(c, 1'b1, 32'd200, VEC_A);
    exp_vec(c, 32'd200, VEC_A);
    drain();

    // 3: vector store, grant low in cycles 2 and 3
    step();
    c = cyc;
    drive(1'b1, 1'b1, 32'd300, VEC_A);
    exp_w(c + 1, 32'd300, 32'h11);
    exp_w(c + 4, 32'd301, 32'h22);
    exp_w(c + 5, 32'd302, 32'h33);
    exp_w(c + 6, 32'd303, 32'h44);
    exp_w(c + 7, 32'd304, 32'h55);
    exp_w(c + 8, 32'd305, 32'h66);
    exp_e(c + 9, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 192'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      mem_gnt = 1'b0;
      #2;
      chk("stall_we", 64'(mem_we), 64'd1);
      chk("stall_addr", 64'(mem_addr), 64'd301);
      chk("stall_wd", 64'(mem_wd), 64'h22);
      chk("stall_ready", 64'(req_ready), 64'd0);
    end
    step();
    mem_gnt = 1'b1;
    drain();

    // 4: range checks; a new request is accepted in the error cycle
    step();
    c = cyc;
    drive(1'b1, 1'b1, 32'd29995, VEC_A);
    exp_e(c + 1, 1'b1);
    step();
    chk("err_cycle_ready", 64'(req_ready), 64'd1);
    c1 = cyc;
    drive(1'b1, 1'b0, 32'd29999, {160'h0, 32'h1234_5678});
    exp_w(c1 + 1, 32'd29999, 32'h1234_5678);
    exp_e(c1 + 2, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 192'h0);
    drain();

    issue(c, 1'b1, 32'd29994, VEC_B);
    exp_vec(c, 32'd29994, VEC_B);
    drain();

    issue(c, 1'b0, 32'd30000, {160'h0, 32'hAAAA_5555});
    exp_e(c + 1, 1'b1);
    drain();

    issue(c, 1'b0, 32'hFFFF_FFFF, {160'h0, 32'hAAAA_5555});
    exp_e(c + 1, 1'b1);
    drain();

    issue(c, 1'b1, 32'hFFFF_FFFF, VEC_A);
    exp_e(c + 1, 1'b1);
    drain();

    // 5: back-to-back vector then scalar with req_valid held high
    step();
    c = cyc;
    drive(1'b1, 1'b1, 32'd400, VEC_B);
    exp_vec(c, 32'd400, VEC_B);
    exp_w(c + 7, 32'd700, 32'h0BAD_CAFE);
    exp_e(c + 8, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'd700, {160'h0, 32'h0BAD_CAFE});
    #2;
    chk("b2b_ready_busy", 64'(req_ready), 64'd0);
    for (int k = 0; k < 5; k++) step();
    #2;
    chk("b2b_ready_last", 64'(req_ready), 64'd1);
    step();
    drive(1'b0, 1'b0, 32'h0, 192'h0);
    drain();

    // 6: reset during the third vector write
    issue(c, 1'b1, 32'd500, VEC_A);
    exp_w(c + 1, 32'd500, 32'h11);
    exp_w(c + 2, 32'd501, 32'h22);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", 64'(req_ready), 64'd1);
    issue(c, 1'b0, 32'd600, {160'h0, 32'hCAFE_F00D});
    exp_w(c + 1, 32'd600, 32'hCAFE_F00D);
    exp_e(c + 2, 1'b0);
    drain();

    chk("final_writes_pending", 64'(wq.size()), 64'd0);
    chk("final_events_pending", 64'(eq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_store_seq.md
# dmem_store_seq

Store sequencer for the vector processor's data memory. It is the write-side counterpart of the data-memory read path. It accepts one scalar or vector (6-lane) store request per handshake and serializes it into single-word writes on a 32-bit RAM write port, honouring a memory grant. It sits between the execute/memory stage and the data RAM. Its lane-to-address packing matches the read side: lane k goes to `address+k`.

## Interface
Parameters:
- `S`, 32, scalar word width / address width
- `V`, 192, vector width (`V = LANES*S`)
- `LANES`, 6, words per vector
- `SIZE`, 30000, data-memory depth in words

Ports:
- `clk`  in  1  clock. One clock domain; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  store request valid
- `req_ready`  out  1  sequencer can accept a request this cycle
- `req_isVector`  in  1  1 = 6-word vector store, 0 = scalar store
- `req_address`  in  S  base word address
- `req_data`  in  V  store data; a scalar store uses only `[S-1:0]`
- `mem_we`  out  1  word write request to the RAM
- `mem_addr`  out  S  word address of the write
- `mem_wd`  out  S  write data
- `mem_gnt`  in  1  RAM accepts the write this cycle (`mem_we & mem_gnt` = write committed)
- `done`  out  1  one-cycle pulse: request fully written
- `err`  out  1  one-cycle pulse: request rejected because it is out of range

## Operation
- FSM states:
  - IDLE: no request in progress.
  - WRITE: issuing the words of an accepted request.
- Accept occurs on a rising edge where `req_valid & req_ready`. On accept:
  - Latch address and data.
  - Set `cnt = req_isVector ? LANES : 1`.
  - Clear lane index `idx = 0`.
- Range check, done at accept: `req_address + cnt > SIZE`.
  - Compute the sum in S+1 bits so it cannot wrap.
  - On failure: no write is issued, FSM stays in or returns to IDLE, `err` pulses the next cycle.
- In WRITE:
  - `mem_we = 1`
  - `mem_addr = base + idx`
  - `mem_wd = data[idx*S +: S]`
- Lane advance in WRITE:
  - If `mem_gnt` is high, `idx` increments.
  - If `mem_gnt` is low, all outputs hold stable (no advance, no change).
- When the write at `idx == cnt-1` is granted, the FSM goes to IDLE. If a new request is accepted in that same cycle, it goes directly to WRITE instead.
- `req_ready` is high when either holds:
  - state is IDLE, or
  - state is WRITE, `idx == cnt-1` and `mem_gnt` is high.

  This is a combinational path from `mem_gnt`, which the upstream stage must tolerate.
- `req_*` inputs are ignored when `req_ready` is low.
- Outside WRITE: `mem_we = 0`, and `mem_addr` and `mem_wd` are 0.

## Timing
- Reset values: `req_ready=1`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`, `done=0`, `err=0`; state IDLE, `idx=0`.
- Reset asserted mid-request abandons the request immediately (asynchronously): `mem_we` drops, no `done` pulse.
- Latency with `mem_gnt` held high, request accepted at edge 0:
  - Scalar: write in cycle 1, `done` in cycle 2.
  - Vector: writes in cycles 1–6, `done` in cycle 7.
- Each low `mem_gnt` cycle adds one cycle to the latency.
- Back-to-back requests: the next request's first write is in the cycle after the previous request's last granted write (no bubble). `done` for the first request coincides with that write.
- `err` pulses 1 cycle after the rejected accept. `req_ready` stays high, so a new request can be accepted in the error cycle.
- `done` and `err` are registered and never high together.

## Structure
- Shared package `dmem_pkg` holds:
  - constants `S`, `V`, `LANES`, `SIZE`
  - `typedef enum logic {IDLE, WRITE} store_state_t`

  The read side imports the same constants.
- One natural sub-module, `dmem_lane_sel`: a combinational selector from the V-bit data and lane index to an S-bit word.
- Everything else (FSM, counters, range check) lives in the top module.

## Test plan
1. Scalar store, `req_address=100`, `req_data[31:0]=0xDEADBEEF`, `mem_gnt=1`:
   - Exactly one write {100, 0xDEADBEEF} in cycle 1.
   - `done` in cycle 2.
2. Vector store at 200, lanes `0x11..0x66`, `mem_gnt=1`:
   - Writes (200,0x11) … (205,0x66) in cycles 1–6.
   - `done` in cycle 7.
   - Reading back through the read path with `isVector=1` returns identical 192-bit data.
3. Vector store with `mem_gnt` low in cycles 2 and 3:
   - Address and data hold at lane 1 while stalled.
   - All 6 writes occur, `done` in cycle 9.
4. Out-of-range requests:
   - Vector at 29995 → no `mem_we`, `err` pulse in cycle 1.
   - Vector at 29994 → succeeds, last write at 29999.
   - Scalar at 30000 → `err`.
   - Address `0xFFFFFFFF` → `err` (no wrap).
5. Back-to-back vector then scalar, `req_valid` held high:
   - Scalar accepted in the vector's 6th write cycle.
   - Scalar write in cycle 7, coinciding with the vector's `done`.
   - Scalar `done` in cycle 8.
6. `rst_n` pulsed low during the 3rd vector write:
   - `mem_we` drops immediately, no `done`.
   - After release, `req_ready=1` and a new scalar store completes normally.
